pipe_ctrl: RTL
==============

Name: pipe_ctrl

Overview:
Central pipeline sequencer for the 5-stage RISC-V core. Drives the enable and synchronous-clear inputs of the PC register and the four inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). Handles four conditions: data-memory wait freeze, branch/jump redirect flush, load-use stall, and an ecall/ebreak halt-drain sequence. Also keeps saturating stall and flush event counters.

Parameters:
CNT_W, 16, width of stall_cnt and flush_cnt
REG_W, 5, register-index width

Ports:
clk  in  1  clock, rising edge
r  in  1  asynchronous active-high reset
mem_busy  in  1  data memory not ready; MEM stage must hold
imem_busy  in  1  instruction memory not ready; fetch must hold
ex_redirect  in  1  taken branch/jump resolved in EX
ex_memread  in  1  instruction in EX is a load
ex_rd  in  REG_W  destination of EX instruction
id_rs1, id_rs2  in  REG_W  sources of ID instruction
id_use_rs1, id_use_rs2  in  1  ID instruction reads rs1/rs2
halt_req  in  1  ID holds ecall/ebreak
resume  in  1  leave HALTED
pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1  register enables
ifid_r, idex_r, exmem_r, memwb_r  out  1  synchronous clears (bubble insert)
halted  out  1  core quiesced
stall_cnt  out  CNT_W  cycles with pc_en=0 in RUN
flush_cnt  out  CNT_W  accepted redirects

Behaviour:
- Control outputs are combinational from the current state and inputs. Counters and state are registered.
- Downstream registers give clear priority over enable. This block never asserts en and r together on one register, except during reset.
- While r=1:
  - all *_r=1, all *_en=0, halted=0.
  - state=RUN, drain_cnt=0, counters=0, applied asynchronously.
- Default (RUN, no condition): all en=1, all r=0.
- RUN priority, highest first:
  1. mem_busy: all five en=0, all r=0 (full freeze). Any other condition is deferred. Because the EX instruction is frozen, ex_redirect re-presents on the next cycle.
  2. ex_redirect: pc_en=1, ifid_r=1, idex_r=1. Later stages are enabled. flush_cnt+1. A simultaneous halt_req is discarded, since halt is on the wrong path.
  3. Load-use: ex_memread && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)). Response: pc_en=0, ifid_en=0, idex_r=1; EX/MEM and MEM/WB enabled. halt_req is ignored this cycle.
  4. halt_req: pc_en=0, ifid_en=0, idex_r=1. Load drain_cnt=3 and go to DRAIN.
  5. imem_busy: pc_en=0, ifid_en=0, idex_r=1.
- DRAIN:
  - pc_en=0, ifid_en=0, idex_r=1. exmem_en and memwb_en = !mem_busy.
  - drain_cnt decrements only on cycles with mem_busy=0.
  - Go to HALTED on the cycle drain_cnt goes 1→0.
  - ex_redirect is not possible here (EX holds bubbles) and is ignored.
- HALTED:
  - all en=0, all r=0, halted=1.
  - If resume=1: next state RUN, and pc_en=1, ifid_r=1 in that same cycle, so fetch restarts at PC+4 and the stale IF/ID is cleared.
- stall_cnt: +1 each RUN cycle with pc_en=0, excluding the mem_busy freeze. It counts load-use, halt entry and imem_busy cycles.
- Both counters saturate at 2^CNT_W−1.
- Reset asserted mid-DRAIN or mid-HALTED returns to RUN.

Test Plan:
- Load-use: ex_memread=1, ex_rd=5, id_rs2=5, id_use_rs2=1 for one cycle → pc_en=0, ifid_en=0, idex_r=1, exmem_en=1; stall_cnt 0→1. Repeat with ex_rd=0 → no stall.
- Redirect: ex_redirect=1 together with halt_req=1 → ifid_r=1, idex_r=1, pc_en=1; state stays RUN; flush_cnt=1.
- Freeze: mem_busy=1 for 3 cycles while ex_redirect=1 → all en=0, all r=0, flush_cnt unchanged. On the cycle after mem_busy drops, flush occurs and flush_cnt=1.
- Halt drain: halt_req=1, then mem_busy=1 on the 2nd DRAIN cycle → halted asserts exactly 4 cycles after acceptance (3 advancing + 1 frozen). Then resume=1 → pc_en=1, ifid_r=1, halted=0 on the next cycle.
- Saturation: CNT_W=2, hold imem_busy=1 for 6 cycles → stall_cnt sticks at 3.
- Async reset: assert r mid-DRAIN between clock edges → outputs switch immediately to all r=1 / en=0. After release, state is RUN and counters are 0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central sequencer for the 5-stage pipeline.
// Produces enable / synchronous-clear strobes for the PC and the four
// inter-stage registers, resolving memory freeze, redirect flush, load-use
// stall, fetch wait and the ecall/ebreak halt-drain sequence.
// Keeps saturating counters of stall cycles and accepted redirects.
module pipe_ctrl #(
  parameter int CNT_W = 16,
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             r,
  input  logic             mem_busy,
  input  logic             imem_busy,
  input  logic             ex_redirect,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             halt_req,
  input  logic             resume,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_r,
  output logic             idex_r,
  output logic             exmem_r,
  output logic             memwb_r,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  // Instructions still in flight behind a halting ecall/ebreak
  // (ID/EX, EX/MEM, MEM/WB) that must retire before the core is quiet.
  localparam logic [1:0] DRAIN_DEPTH = 2'd3;

  state_t     state, state_nxt;
  logic [1:0] drain_cnt, drain_nxt;

  // Event strobes from the output decoder, consumed by the counters.
  logic stall_ev, flush_ev;

  logic rs1_hit, rs2_hit, load_use;

  // Hazard: the load in EX writes a register the ID instruction reads.
  // x0 is never a real dependency.
  always_comb begin
    rs1_hit  = id_use_rs1 && (id_rs1 == ex_rd);
    rs2_hit  = id_use_rs2 && (id_rs2 == ex_rd);
    load_use = ex_memread && (ex_rd != '0) && (rs1_hit || rs2_hit);
  end

  // State and drain counter register.
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state     <= RUN;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    drain_nxt = drain_cnt;
    unique case (state)
      RUN: begin
        // Halt is only taken when nothing of higher priority claims the
        // cycle; a redirect means the ecall is on the wrong path.
        if (!mem_busy && !ex_redirect && !load_use && halt_req) begin
          state_nxt = DRAIN;
          drain_nxt = DRAIN_DEPTH;
        end
      end
      DRAIN: begin
        // A frozen MEM stage advances nothing, so the drain does not count.
        if (!mem_busy) begin
          drain_nxt = drain_cnt - 2'd1;
          if (drain_cnt == 2'd1) state_nxt = HALTED;
        end
      end
      HALTED: begin
        if (resume) state_nxt = RUN;
      end
      default: begin
        state_nxt = RUN;
        drain_nxt = '0;
      end
    endcase
  end

  // Output decode. A register being cleared always has its enable low,
  // so en and clear never coincide outside reset.
  always_comb begin
    pc_en    = 1'b1;
    ifid_en  = 1'b1;
    idex_en  = 1'b1;
    exmem_en = 1'b1;
    memwb_en = 1'b1;
    ifid_r   = 1'b0;
    idex_r   = 1'b0;
    exmem_r  = 1'b0;
    memwb_r  = 1'b0;
    halted   = 1'b0;
    stall_ev = 1'b0;
    flush_ev = 1'b0;
    unique case (state)
      RUN: begin
        if (mem_busy) begin
          // Full freeze; the frozen EX re-presents any redirect next cycle.
          pc_en    = 1'b0;
          ifid_en  = 1'b0;
          idex_en  = 1'b0;
          exmem_en = 1'b0;
          memwb_en = 1'b0;
        end else if (ex_redirect) begin
          // Fetch the target, squash the two wrong-path instructions.
          ifid_en  = 1'b0;
          idex_en  = 1'b0;
          ifid_r   = 1'b1;
          idex_r   = 1'b1;
          flush_ev = 1'b1;
        end else if (load_use || halt_req || imem_busy) begin
          // Hold PC and IF/ID, inject a bubble into EX, let older work move.
          pc_en    = 1'b0;
          ifid_en  = 1'b0;
          idex_en  = 1'b0;
          idex_r   = 1'b1;
          stall_ev = 1'b1;
        end
      end
      DRAIN: begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        idex_r   = 1'b1;
        exmem_en = !mem_busy;
        memwb_en = !mem_busy;
      end
      HALTED: begin
        halted   = 1'b1;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        exmem_en = 1'b0;
        memwb_en = 1'b0;
        // On resume, fetch restarts at PC+4 and the stale IF/ID is dropped.
        pc_en    = resume;
        ifid_r   = resume;
      end
      default: begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        exmem_en = 1'b0;
        memwb_en = 1'b0;
      end
    endcase
    // Reset dominates combinationally so the pipe is cleared at once.
    if (r) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
      ifid_r   = 1'b1;
      idex_r   = 1'b1;
      exmem_r  = 1'b1;
      memwb_r  = 1'b1;
      halted   = 1'b0;
      stall_ev = 1'b0;
      flush_ev = 1'b0;
    end
  end

  // Saturating event counters.
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_ev && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + 1'b1;
      if (flush_ev && (flush_cnt != {CNT_W{1'b1}})) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule
